// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the multiplexed hex display scanner.
package hex_disp_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, GAP} hd_state_t;

  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam int         MAX_DIGITS = 32;

  // All digit enables released (active-low); callers narrow to their width.
  function automatic logic [MAX_DIGITS-1:0] DIG_OFF();
    return '1;
  endfunction
endpackage

// File: rtl/decodeur7seg.sv
// Hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module decodeur7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);
  always_comb begin
    seg_n = 7'h7F;
    case (hex)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = 7'h7F;
    endcase
  end
endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed common-anode hex display driver with frame-aligned updates,
// per-slot dead time and optional leading-zero blanking.
module hex_display_scanner
  import hex_disp_pkg::*;
#(
  parameter int NDIGITS = 8,
  parameter int DIV     = 50000,
  parameter int BLANK   = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   lz_blank,
  input  logic                   wr_valid,
  input  logic [4*NDIGITS-1:0]   wr_data,
  output logic                   wr_ready,
  output logic [6:0]             seg_n,
  output logic [NDIGITS-1:0]     dig_n,
  output logic                   frame_done
);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int W  = 4 * NDIGITS;
  localparam logic [NDIGITS-1:0] DIG_ALL = NDIGITS'(DIG_OFF());

  hd_state_t          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [W-1:0]       active_q, active_d;
  logic [W-1:0]       shadow_q, shadow_d;
  logic               pending_q, pending_d;
  logic               lz_q, lz_d;
  logic [6:0]         seg_q, seg_d;
  logic [NDIGITS-1:0] dig_q, dig_d;
  logic               fd_q, fd_d;

  logic [3:0]         nib;
  logic [6:0]         dec_seg;
  logic [NDIGITS-1:0] lz_mask;
  logic               tail_nz;
  logic               slot_end, frame_end, drive_on;

  assign nib = active_q[{idx_q, 2'b00} +: 4];

  decodeur7seg u_dec (
    .hex   (nib),
    .seg_n (dec_seg)
  );

  // lz_mask[i] is set when nibbles i..NDIGITS-1 are all zero; digit 0 is never masked.
  always_comb begin
    tail_nz = 1'b0;
    lz_mask = '0;
    for (int i = NDIGITS - 1; i > 0; i--) begin
      tail_nz    = tail_nz | (|active_q[4*i +: 4]);
      lz_mask[i] = ~tail_nz;
    end
  end

  assign slot_end  = (state_q == GAP) && (cnt_q == CW'(DIV - 1));
  assign frame_end = en && slot_end && (idx_q == IW'(NDIGITS - 1));
  assign drive_on  = en && (state_q == DRIVE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    lz_d      = lz_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = DRIVE;
          cnt_d   = '0;
          idx_d   = '0;
          lz_d    = lz_blank;
        end
        DRIVE: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DIV - BLANK - 1)) state_d = GAP;
        end
        GAP: begin
          if (slot_end) begin
            state_d = DRIVE;
            cnt_d   = '0;
            lz_d    = lz_blank;
            idx_d   = frame_end ? '0 : idx_q + IW'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Commit and accept are mutually exclusive: a commit needs pending, which blocks ready.
    if (frame_end && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (wr_valid && !pending_q) begin
      if (state_q == IDLE) begin
        active_d = wr_data;
      end else begin
        shadow_d  = wr_data;
        pending_d = 1'b1;
      end
    end

    seg_d = drive_on ? dec_seg : SEG_OFF;
    dig_d = DIG_ALL;
    if (drive_on && !(lz_q && lz_mask[idx_q])) dig_d[idx_q] = 1'b0;
    fd_d  = frame_end;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      lz_q      <= 1'b0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      seg_q     <= SEG_OFF;
      dig_q     <= DIG_ALL;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      lz_q      <= lz_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
      fd_q      <= fd_d;
    end
  end

  assign wr_ready   = ~pending_q;
  assign seg_n      = seg_q;
  assign dig_n      = dig_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_hex_display_scanner.sv
// Randomized + directed bench for hex_display_scanner against a time-based display model.
module tb_hex_display_scanner;
  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = N * DIV;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        en = 1'b0;
  logic        lz_blank = 1'b0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_ready;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // Model: ph = cycles since scanning started (-1 when idle); everything else derives from it.
  int          ph = -1;
  logic [15:0] m_act = '0, m_sh = '0;
  logic        m_pend = 1'b0, m_lz = 1'b0;
  logic [6:0]  seg_tab [16];

  hex_display_scanner #(.NDIGITS(N), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .lz_blank   (lz_blank),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .seg_n      (seg_n),
    .dig_n      (dig_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    logic [6:0] es;
    logic [3:0] ed;
    logic       ef, acc;
    int         off, dg;
    es = 7'h7F; ed = 4'hF; ef = 1'b0;
    if (en && ph >= 0) begin
      off = ph % DIV;
      dg  = (ph / DIV) % N;
      if (off < DIV - BLANK) begin
        es = seg_tab[m_act[4*dg +: 4]];
        if (!(m_lz && dg > 0 && (m_act >> (4*dg)) == 16'h0)) ed[dg] = 1'b0;
      end
      ef = (ph % FRAME) == FRAME - 1;
    end
    acc = wr_valid && !m_pend;
    if (ef && m_pend) begin
      m_act  = m_sh;
      m_pend = 1'b0;
    end
    if (acc) begin
      if (ph < 0) m_act = wr_data;
      else begin
        m_sh   = wr_data;
        m_pend = 1'b1;
      end
    end
    if (en && (ph < 0 || ph % DIV == DIV - 1)) m_lz = lz_blank;
    ph = en ? ph + 1 : -1;
    @(posedge clk);
    #1;
    chk("seg_n", 32'(seg_n), 32'(es));
    chk("dig_n", 32'(dig_n), 32'(ed));
    chk("frame_done", 32'(frame_done), 32'(ef));
    chk("wr_ready", 32'(wr_ready), 32'(!m_pend));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_seg_n", 32'(seg_n), 32'h7F);
    chk("rst_dig_n", 32'(dig_n), 32'hF);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    chk("rst_wr_ready", 32'(wr_ready), 32'h1);
    ph = -1; m_act = '0; m_sh = '0; m_pend = 1'b0; m_lz = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic idle_write(input logic [15:0] v);
    en = 1'b0; wr_valid = 1'b0;
    step();
    wr_valid = 1'b1; wr_data = v;
    step();
    wr_valid = 1'b0;
    en = 1'b1;
  endtask

  task automatic run_to_phase(input int target);
    int budget;
    budget = 200;
    while (en && (ph < 0 || ph % FRAME != target) && budget > 0) begin
      step();
      budget--;
    end
    chk("phase_reached", 32'(budget > 0), 32'h1);
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    #3;
    do_reset();

    // Enable from reset: digit 0 shows '0' two cycles later.
    en = 1'b1;
    run(2);
    chk("first_dig", 32'(dig_n), 32'hE);
    chk("first_seg", 32'(seg_n), 32'h40);
    run(40);

    // Load in idle, then scan full frames.
    idle_write(16'h1A3F);
    run(70);

    // Mid-frame write during digit 1, then a held second write that stalls.
    idle_write(16'h1234);
    run_to_phase(DIV + 2);
    wr_valid = 1'b1; wr_data = 16'h0005;
    step();
    wr_valid = 1'b1; wr_data = 16'($urandom);
    run(80);
    wr_valid = 1'b0;
    run(40);

    // Leading-zero blanking.
    lz_blank = 1'b1;
    idle_write(16'h0050);
    run(40);
    idle_write(16'h0000);
    run(40);
    lz_blank = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      en       = ($urandom % 64) != 0;
      wr_valid = ($urandom % 3) == 0;
      wr_data  = 16'($urandom);
      if ($urandom % 50 == 0) lz_blank = 1'($urandom);
      step();
    end
    wr_valid = 1'b0;

    // Drop enable mid-frame, then restart at digit 0.
    en = 1'b1;
    run(20);
    en = 1'b0;
    run(2);
    en = 1'b1;
    run(20);

    // Asynchronous reset mid-slot with a write pending.
    idle_write(16'hBEEF);
    run_to_phase(2*DIV + 3);
    wr_valid = 1'b1; wr_data = 16'h7777;
    step();
    wr_valid = 1'b0;
    run(2);
    do_reset();
    en = 1'b1;
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
